// File: rtl/axi4_mem_slave.sv
`default_nettype none
// ============================================================================
// axi4_mem_slave : AXI4 INCR/FIXED burst responder backed by a word RAM
// Revision       : 1.0
// ============================================================================
module axi4_mem_slave #(
   parameter int C_AXI_ID_WIDTH   = 1,
   parameter int C_AXI_ADDR_WIDTH = 32,
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_MEM_DEPTH_LOG2 = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [C_AXI_ID_WIDTH-1:0]       s_axi_awid,
   input  logic [C_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [7:0]                      s_axi_awlen,
   input  logic [1:0]                      s_axi_awburst,
   input  logic                            s_axi_awvalid,
   output logic                            s_axi_awready,
   input  logic [C_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [C_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                            s_axi_wlast,
   input  logic                            s_axi_wvalid,
   output logic                            s_axi_wready,
   output logic [C_AXI_ID_WIDTH-1:0]       s_axi_bid,
   output logic [1:0]                      s_axi_bresp,
   output logic                            s_axi_bvalid,
   input  logic                            s_axi_bready,
   input  logic [C_AXI_ID_WIDTH-1:0]       s_axi_arid,
   input  logic [C_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [7:0]                      s_axi_arlen,
   input  logic [1:0]                      s_axi_arburst,
   input  logic                            s_axi_arvalid,
   output logic                            s_axi_arready,
   output logic [C_AXI_ID_WIDTH-1:0]       s_axi_rid,
   output logic [C_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                      s_axi_rresp,
   output logic                            s_axi_rlast,
   output logic                            s_axi_rvalid,
   input  logic                            s_axi_rready
);
   localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int IDX_W  = C_MEM_DEPTH_LOG2;
   localparam int DEPTH  = 1 << IDX_W;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   logic [C_AXI_DATA_WIDTH-1:0] mem_q [DEPTH];

   w_state_t                    w_state_q, w_state_d;
   logic [C_AXI_ID_WIDTH-1:0]   w_id_q, w_id_d;
   logic [IDX_W-1:0]            w_idx_q, w_idx_d;
   logic [7:0]                  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
   logic                        w_fixed_q, w_fixed_d, w_nowr_q, w_nowr_d, w_err_q, w_err_d;

   r_state_t                    r_state_q, r_state_d;
   logic [C_AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
   logic [IDX_W-1:0]            r_idx_q, r_idx_d, r_next_idx;
   logic [7:0]                  r_len_q, r_len_d, r_cnt_q, r_cnt_d;
   logic                        r_fixed_q, r_fixed_d, r_err_q, r_err_d, r_last_q, r_last_d;
   logic [C_AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic unused_addr_bits;

   assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

   assign aw_hs = s_axi_awready && s_axi_awvalid;
   assign w_hs  = s_axi_wready  && s_axi_wvalid;
   assign b_hs  = s_axi_bvalid  && s_axi_bready;
   assign ar_hs = s_axi_arready && s_axi_arvalid;
   assign r_hs  = s_axi_rvalid  && s_axi_rready;

   // w_nowr blocks RAM updates (bad burst type or beats past awlen); w_err drives SLVERR
   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_idx_d   = w_idx_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_fixed_d = w_fixed_q;
      w_nowr_d  = w_nowr_q;
      w_err_d   = w_err_q;
      unique case (w_state_q)
         W_IDLE: if (aw_hs) begin
            w_id_d    = s_axi_awid;
            w_idx_d   = s_axi_awaddr[OFF_W +: IDX_W];
            w_len_d   = s_axi_awlen;
            w_cnt_d   = 8'd0;
            w_fixed_d = (s_axi_awburst == BURST_FIXED);
            w_nowr_d  = s_axi_awburst[1];
            w_err_d   = s_axi_awburst[1];
            w_state_d = W_DATA;
         end
         W_DATA: if (w_hs) begin
            w_cnt_d = w_cnt_q + 8'd1;
            if (!w_fixed_q) w_idx_d = w_idx_q + IDX_ONE;
            if (s_axi_wlast) begin
               w_state_d = W_RESP;
               if (w_cnt_q != w_len_q) w_err_d = 1'b1;
            end else if (w_cnt_q == w_len_q) begin
               w_nowr_d = 1'b1;
               w_err_d  = 1'b1;
            end
         end
         W_RESP: if (b_hs) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_idx_q   <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_fixed_q <= 1'b0;
         w_nowr_q  <= 1'b0;
         w_err_q   <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_idx_q   <= w_idx_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_fixed_q <= w_fixed_d;
         w_nowr_q  <= w_nowr_d;
         w_err_q   <= w_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (w_hs && !w_nowr_q) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (s_axi_wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
         end
      end
   end

   // Read data is fetched from the pre-edge RAM, so a colliding write is not visible
   always_comb begin
      r_state_d  = r_state_q;
      r_id_d     = r_id_q;
      r_idx_d    = r_idx_q;
      r_len_d    = r_len_q;
      r_cnt_d    = r_cnt_q;
      r_fixed_d  = r_fixed_q;
      r_err_d    = r_err_q;
      r_last_d   = r_last_q;
      r_data_d   = r_data_q;
      r_next_idx = r_fixed_q ? r_idx_q : (r_idx_q + IDX_ONE);
      unique case (r_state_q)
         R_IDLE: if (ar_hs) begin
            r_id_d    = s_axi_arid;
            r_idx_d   = s_axi_araddr[OFF_W +: IDX_W];
            r_len_d   = s_axi_arlen;
            r_cnt_d   = 8'd0;
            r_fixed_d = (s_axi_arburst == BURST_FIXED);
            r_err_d   = s_axi_arburst[1];
            r_last_d  = (s_axi_arlen == 8'd0);
            r_data_d  = s_axi_arburst[1] ? '0 : mem_q[s_axi_araddr[OFF_W +: IDX_W]];
            r_state_d = R_DATA;
         end
         R_DATA: if (r_hs) begin
            if (r_last_q) begin
               r_state_d = R_IDLE;
            end else begin
               r_idx_d  = r_next_idx;
               r_cnt_d  = r_cnt_q + 8'd1;
               r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
               r_data_d = r_err_q ? '0 : mem_q[r_next_idx];
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_idx_q   <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_fixed_q <= 1'b0;
         r_err_q   <= 1'b0;
         r_last_q  <= 1'b0;
         r_data_q  <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_idx_q   <= r_idx_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_fixed_q <= r_fixed_d;
         r_err_q   <= r_err_d;
         r_last_q  <= r_last_d;
         r_data_q  <= r_data_d;
      end
   end

   // Every output is forced low for the whole time rst is high
   assign s_axi_awready = !rst && (w_state_q == W_IDLE);
   assign s_axi_wready  = !rst && (w_state_q == W_DATA);
   assign s_axi_bvalid  = !rst && (w_state_q == W_RESP);
   assign s_axi_bid     = rst ? '0 : w_id_q;
   assign s_axi_bresp   = (rst || !w_err_q) ? RESP_OKAY : RESP_SLVERR;
   assign s_axi_arready = !rst && (r_state_q == R_IDLE);
   assign s_axi_rvalid  = !rst && (r_state_q == R_DATA);
   assign s_axi_rid     = rst ? '0 : r_id_q;
   assign s_axi_rdata   = rst ? '0 : r_data_q;
   assign s_axi_rresp   = (rst || !r_err_q) ? RESP_OKAY : RESP_SLVERR;
   assign s_axi_rlast   = s_axi_rvalid && r_last_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_mem_slave.sv
`default_nettype none
// ============================================================================
// tb_axi4_mem_slave : randomized self-checking bench with a word-array memory model
// Revision          : 1.0
// ============================================================================
module tb_axi4_mem_slave;
   localparam int IDW   = 4;
   localparam int DEPTH = 256;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [IDW-1:0]  s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
   logic [31:0]     s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
   logic [7:0]      s_axi_awlen, s_axi_arlen;
   logic [1:0]      s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
   logic [3:0]      s_axi_wstrb;
   logic            s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
   logic            s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
   logic            s_axi_rlast, s_axi_rvalid, s_axi_rready;

   axi4_mem_slave #(
      .C_AXI_ID_WIDTH(IDW), .C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(32), .C_MEM_DEPTH_LOG2(8)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready),
      .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
   );

   always #5 clk = ~clk;

   logic [31:0] mdl [DEPTH];
   logic [31:0] wd_arr [256];
   logic [3:0]  ws_arr [256];
   logic [38:0] exp_r [$];
   logic [5:0]  exp_b [$];
   logic [31:0] got_r [$];
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic finish_run();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   endtask

   function automatic void mdl_write(input int w, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++) if (s[b]) mdl[w][8*b +: 8] = d[8*b +: 8];
   endfunction

   function automatic logic rr_pick(input int mode, input int n);
      case (mode)
         0:       return 1'b1;
         1:       return 1'($urandom_range(0, 1));
         default: return (n % 3) != 1;
      endcase
   endfunction

   // Response checker: every presented beat must equal the head of the expected queue
   always @(negedge clk) begin
      if (!rst) begin
         if (s_axi_rvalid) begin
            if (exp_r.size() == 0) chk("r_unexpected", s_axi_rvalid, 1'b0);
            else begin
               chk("r_beat", {s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rdata}, exp_r[0]);
               if (s_axi_rready) begin
                  got_r.push_back(s_axi_rdata);
                  void'(exp_r.pop_front());
               end
            end
         end
         if (s_axi_bvalid) begin
            if (exp_b.size() == 0) chk("b_unexpected", s_axi_bvalid, 1'b0);
            else begin
               chk("b_resp", {s_axi_bid, s_axi_bresp}, exp_b[0]);
               if (s_axi_bready) void'(exp_b.pop_front());
            end
         end
      end
   end

   task automatic do_write(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int nbeats, input int abort_at,
                           input bit gaps, input bit slow_b);
      int idx, t;
      bit err;
      err = burst[1] || (nbeats != int'(len) + 1);
      idx = int'(addr[9:2]);
      exp_b.push_back({id, err ? 2'b10 : 2'b00});
      s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
      s_axi_awvalid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!s_axi_awready && t < 64);
      chk("aw_ready", s_axi_awready, 1'b1);
      if (!s_axi_awready) finish_run();
      @(posedge clk); #1;
      s_axi_awvalid = 1'b0;
      @(negedge clk);
      chk("w_ready_latency", s_axi_wready, 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < nbeats; i++) begin
         if (i == abort_at) return;
         if (gaps) while ($urandom_range(0, 3) == 0) begin
            s_axi_wvalid = 1'b0;
            @(posedge clk); #1;
         end
         s_axi_wvalid = 1'b1; s_axi_wdata = wd_arr[i]; s_axi_wstrb = ws_arr[i];
         s_axi_wlast = (i == nbeats - 1);
         t = 0;
         do begin @(negedge clk); t++; end while (!s_axi_wready && t < 64);
         if (!s_axi_wready) begin chk("w_ready", s_axi_wready, 1'b1); finish_run(); end
         if (!burst[1] && i <= int'(len))
            mdl_write((burst == 2'b00) ? idx : (idx + i) % DEPTH, wd_arr[i], ws_arr[i]);
         @(posedge clk); #1;
      end
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      s_axi_bready = !slow_b;
      @(negedge clk);
      chk("b_latency", {s_axi_bvalid, s_axi_wready}, 2'b10);
      @(posedge clk); #1;
      t = 0;
      while (exp_b.size() != 0) begin
         s_axi_bready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         if (++t > 64) begin chk("b_timeout", exp_b.size(), 0); finish_run(); end
      end
      s_axi_bready = 1'b0;
      @(negedge clk);
      chk("aw_after_b", s_axi_awready, 1'b1);
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int mode, input int abort_at);
      int idx, t, n;
      logic [31:0] d;
      idx = int'(addr[9:2]);
      for (int i = 0; i <= int'(len); i++) begin
         d = burst[1] ? 32'h0 : mdl[(burst == 2'b00) ? idx : (idx + i) % DEPTH];
         exp_r.push_back({id, burst[1] ? 2'b10 : 2'b00, (i == int'(len)), d});
      end
      got_r.delete();
      s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
      s_axi_arvalid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!s_axi_arready && t < 64);
      chk("ar_ready", s_axi_arready, 1'b1);
      if (!s_axi_arready) finish_run();
      @(posedge clk); #1;
      s_axi_arvalid = 1'b0;
      n = 0;
      s_axi_rready = rr_pick(mode, n);
      while (exp_r.size() != 0) begin
         if (n == abort_at) return;
         @(negedge clk);
         chk("r_valid_held", s_axi_rvalid, 1'b1);
         @(posedge clk); #1;
         n++;
         s_axi_rready = rr_pick(mode, n);
         if (n > 2000) begin chk("r_timeout", exp_r.size(), 0); finish_run(); end
      end
      s_axi_rready = 1'b0;
   endtask

   task automatic do_reset_check();
      rst = 1'b1;
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b0;
      s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
      exp_r.delete(); exp_b.delete();
      @(negedge clk);
      chk("rst_outputs", {s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
                          s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
                          s_axi_rvalid}, 64'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", {s_axi_awready, s_axi_arready}, 2'b11);
      @(posedge clk); #1;
   endtask

   initial begin
      #5_000_000;
      n_chk++;
      $display("FAIL watchdog: time limit reached at %0t", $time);
      finish_run();
   end

   initial begin
      logic [31:0] lit4 [4];
      logic [7:0]  len;
      logic [1:0]  bt;
      int          nb, sel;
      lit4 = '{32'h1, 32'h2, 32'h3, 32'h4};
      s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awburst = '0;
      s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_arid = '0; s_axi_araddr = '0;
      s_axi_arlen = '0; s_axi_arburst = '0;
      do_reset_check();

      // Fill the whole RAM so every later read has a defined expectation
      for (int i = 0; i < 256; i++) begin wd_arr[i] = $urandom; ws_arr[i] = 4'hF; end
      do_write(4'h1, 32'h0, 8'd255, 2'b01, 256, -1, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) begin wd_arr[i] = 32'h0; ws_arr[i] = 4'hF; end
      do_write(4'h2, 32'h0, 8'd3, 2'b01, 4, -1, 1'b0, 1'b0);

      wd_arr[0] = 32'hA5A5A5A5; ws_arr[0] = 4'hF;
      do_write(4'h5, 32'h10, 8'd0, 2'b01, 1, -1, 1'b0, 1'b0);
      chk("mdl_pin_single", mdl[4], 32'hA5A5A5A5);
      do_read(4'h6, 32'h10, 8'd0, 2'b01, 0, -1);
      chk("lit_single_read", got_r[0], 32'hA5A5A5A5);

      wd_arr[0] = 32'h1; wd_arr[1] = 32'hABCD0002; wd_arr[2] = 32'h3; wd_arr[3] = 32'h4;
      ws_arr[0] = 4'hF;  ws_arr[1] = 4'h3;         ws_arr[2] = 4'hF;  ws_arr[3] = 4'hF;
      do_write(4'h7, 32'h0, 8'd3, 2'b01, 4, -1, 1'b0, 1'b0);
      do_read(4'h8, 32'h0, 8'd3, 2'b01, 0, -1);
      for (int i = 0; i < 4; i++) chk("lit_incr_read", got_r[i], lit4[i]);

      do_read(4'h9, 32'h0, 8'd7, 2'b01, 2, -1);
      do_read(4'hA, 32'h20, 8'd7, 2'b01, 1, -1);

      wd_arr[0] = 32'hDEADBEEF; ws_arr[0] = 4'hF;
      do_write(4'hB, 32'h10, 8'd0, 2'b10, 1, -1, 1'b0, 1'b1);
      do_read(4'hC, 32'h10, 8'd0, 2'b01, 0, -1);
      chk("lit_err_write_noop", got_r[0], 32'hA5A5A5A5);
      do_read(4'hD, 32'h40, 8'd2, 2'b11, 1, -1);
      chk("err_read_beats", got_r.size(), 3);

      wd_arr[0] = 32'h55; wd_arr[1] = 32'h66; ws_arr[0] = 4'hF; ws_arr[1] = 4'hF;
      do_write(4'hE, 32'h40, 8'd3, 2'b01, 2, -1, 1'b0, 1'b0);
      wd_arr[2] = 32'h77; ws_arr[2] = 4'hF;
      do_write(4'hF, 32'h80, 8'd1, 2'b01, 3, -1, 1'b1, 1'b0);
      do_read(4'h3, 32'h80, 8'd2, 2'b01, 0, -1);
      do_write(4'h4, 32'hC0, 8'd2, 2'b00, 3, -1, 1'b1, 1'b1);
      do_read(4'h4, 32'hC0, 8'd2, 2'b00, 1, -1);

      wd_arr[0] = 32'h11; wd_arr[1] = 32'h22; wd_arr[2] = 32'h33; wd_arr[3] = 32'h44;
      do_write(4'h1, 32'h3FC, 8'd3, 2'b01, 4, -1, 1'b0, 1'b0);
      chk("mdl_pin_wrap_top", mdl[255], 32'h11);
      chk("mdl_pin_wrap_zero", mdl[0], 32'h22);
      do_read(4'h2, 32'h12340400, 8'd0, 2'b01, 0, -1);
      chk("lit_alias_read", got_r[0], 32'h22);
      do_read(4'h2, 32'h3FC, 8'd3, 2'b01, 0, -1);

      for (int i = 0; i < 8; i++) begin wd_arr[i] = $urandom; ws_arr[i] = 4'hF; end
      do_write(4'h9, 32'h100, 8'd7, 2'b01, 8, 3, 1'b0, 1'b0);
      do_reset_check();
      do_read(4'h9, 32'h100, 8'd7, 2'b01, 0, 3);
      do_reset_check();
      do_read(4'h9, 32'h100, 8'd7, 2'b01, 0, -1);

      for (int k = 0; k < 60; k++) begin
         len = 8'($urandom_range(0, 15));
         sel = $urandom_range(0, 9);
         bt  = (sel == 0) ? 2'($urandom_range(2, 3)) : ((sel < 3) ? 2'b00 : 2'b01);
         if ($urandom_range(0, 1) == 1) begin
            nb = int'(len) + 1;
            if ($urandom_range(0, 7) == 0) nb = ($urandom_range(0, 1) == 1 || nb == 1) ? nb + 1 : nb - 1;
            for (int i = 0; i < nb; i++) begin wd_arr[i] = $urandom; ws_arr[i] = 4'($urandom); end
            do_write(4'($urandom), $urandom, len, bt, nb, -1, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
         end else begin
            do_read(4'($urandom), $urandom, len, bt, $urandom_range(0, 2), -1);
         end
      end

      finish_run();
   end
endmodule
`default_nettype wire
